spi_responder: RTL
==================

Name: spi_responder

Overview:
- Mode-0 SPI responder (slave) sitting in the 122.88 MHz `clock` domain.
- Receives frames driven by an external initiator: SPI_clk, SPI_nCS, SPI_MOSI.
- Deserialises one WIDTH-bit word per frame, MSB first, and presents it with a one-cycle valid strobe.
- Serialises a WIDTH-bit reply word onto SPI_MISO in the same frame.

Parameters:
- WIDTH, 16: bits per frame, for both rx and tx. Legal range 2..32.
- CNT_W, 5: bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock. Must be at least 8x the SPI_clk frequency.
- reset  in  1  asynchronous, active-high reset.
- SPI_clk  in  1  SPI clock from the initiator, asynchronous to clock.
- SPI_nCS  in  1  active-low chip select, asynchronous.
- SPI_MOSI  in  1  serial data in, asynchronous.
- SPI_MISO  out  1  serial data out.
- tx_data  in  WIDTH  reply word, sampled at frame start.
- tx_ack  out  1  one-cycle pulse when tx_data has been sampled.
- rx_data  out  WIDTH  last complete received word; held until the next complete frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_error  out  1  one-cycle pulse when a frame is aborted short.

Behaviour:
- Synchronisers and edge detect:
  - SPI_clk, SPI_nCS and SPI_MOSI each pass through a 2-flop synchroniser, then one extra history flop for edge detection.
  - The synchroniser flops reset to clk=0, nCS=1, MOSI=0.
  - Edges are detected on the synchronised signals. All timing below is measured from the detect cycle, which is 3 clock edges after the pin change.
- Reset values: SPI_MISO=0, rx_data=0, rx_valid=0, tx_ack=0, frame_error=0, state=IDLE, bit count=0, shift registers=0.
- State IDLE:
  - Waits for nCS to be seen high.
  - Then, on an nCS falling edge: load tx shift register <= tx_data, pulse tx_ack, drive SPI_MISO <= tx_data[WIDTH-1], clear the bit count, go to SHIFT.
  - If nCS is already low when reset releases, that frame is ignored. A falling edge is only recognised after a synchronised high has been seen.
- State SHIFT:
  - On an SPI_clk rising edge: shift the synchronised MOSI into the rx shift register LSB and increment the bit count.
  - On an SPI_clk falling edge, while bit count < WIDTH: shift the tx register left and drive SPI_MISO from the new MSB.
  - When the rising edge brings the count to WIDTH: on the next cycle, rx_data <= shift register and rx_valid=1 for exactly one cycle. Then go to WAIT_CS.
- State WAIT_CS:
  - SPI_clk edges are ignored and SPI_MISO is held at 0.
  - nCS rising goes to IDLE with no error.
- Short frame: nCS rising in SHIFT with count < WIDTH:
  - frame_error pulses for one cycle.
  - rx_data is unchanged and rx_valid is not asserted.
  - The state machine goes to IDLE.
- Simultaneous nCS rise and the final rising clock edge in the same detect cycle: the edge wins. The word completes with rx_valid and no frame_error, and the state goes to IDLE.
- SPI_MISO is 0 whenever the state is not SHIFT. No tristate at this level.
- Back-to-back frames: nCS high for at least 3 clock cycles is sufficient. tx_data is re-sampled at every frame start.
- Reset asserted mid-frame: all outputs and state return to reset values immediately. The in-progress frame is discarded.
- The bit count saturates at WIDTH and never wraps.

Test Plan:
- Nominal 16-bit frame: MOSI=0xA5C3, tx_data=0x3C5A, SPI_clk=clock/16 -> rx_data=0xA5C3 with a single rx_valid pulse; MISO bits captured on SPI_clk rising edges = 0x3C5A; one tx_ack at nCS fall.
- Short frame: nCS deasserted after 9 bits -> one frame_error pulse, no rx_valid, rx_data keeps its previous value; the next full frame 0x1234 is received correctly.
- Over-clocked frame: 20 SPI_clk pulses with MOSI=0xFFFF then 0000 -> rx_data=0xFFFF, exactly one rx_valid, MISO=0 after bit 16, no frame_error.
- Reset mid-frame: reset pulsed after 5 bits while nCS stays low -> all outputs 0; no activity until nCS goes high then low; the following frame 0x0F0F is received.
- Back-to-back frames: nCS high for 3 cycles between frames 0x8001 and 0x7FFE, tx_data changed between them -> two rx_valid pulses with the correct words; the second reply reflects the new tx_data.
- Boundary: the last SPI_clk rise and nCS rise synchronised in the same cycle -> rx_valid, no frame_error, state returns to IDLE.

Source files
------------

// File: rtl/spi_responder.sv
// -----------------------------------------------------------------------------
// spi_responder
//
// Mode-0 SPI responder (slave) clocked by the system clock. The three SPI pins
// are asynchronous to `clock`; each goes through a 2-flop synchroniser plus one
// history flop so edges can be detected entirely in the `clock` domain. One
// WIDTH-bit word is received MSB first per frame and presented with a one-cycle
// rx_valid strobe. A WIDTH-bit reply, sampled from tx_data at frame start, is
// shifted out on SPI_MISO during the same frame.
//
// The system clock must run at least 8x the SPI_clk frequency so that every
// SPI_clk half period spans several system clock cycles after synchronisation.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-high reset
//   SPI_clk      in   SPI clock from the initiator (async)
//   SPI_nCS      in   active-low chip select (async)
//   SPI_MOSI     in   serial data in (async)
//   SPI_MISO     out  serial data out, 0 whenever not shifting
//   tx_data      in   reply word, sampled at frame start
//   tx_ack       out  one-cycle pulse when tx_data has been sampled
//   rx_data      out  last complete received word, held between frames
//   rx_valid     out  one-cycle pulse when rx_data updates
//   frame_error  out  one-cycle pulse when a frame ends short
// -----------------------------------------------------------------------------
module spi_responder #(
  parameter int WIDTH = 16,  // bits per frame, 2..32
  parameter int CNT_W = 5    // bit counter width, 2**CNT_W > WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SPI_clk,
  input  logic             SPI_nCS,
  input  logic             SPI_MOSI,
  output logic             SPI_MISO,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_CS
  } state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers. Bit 0 is the metastability flop, bit 1 the synchronised
  // value, bit 2 the history flop used for edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_pipe_q, sclk_pipe_d;
  logic [2:0] ncs_pipe_q,  ncs_pipe_d;
  logic [2:0] mosi_pipe_q, mosi_pipe_d;

  // Counts the first three cycles after reset, until every pipe stage holds a
  // real pin sample rather than its reset value.
  logic [1:0] sync_fill_q, sync_fill_d;

  // Set once nCS has genuinely been seen high; a frame already in progress
  // when reset releases must not be mistaken for a new one.
  logic armed_q, armed_d;

  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[1:0], SPI_clk};
    ncs_pipe_d  = {ncs_pipe_q[1:0],  SPI_nCS};
    mosi_pipe_d = {mosi_pipe_q[1:0], SPI_MOSI};
    sync_fill_d = (sync_fill_q == 2'd3) ? sync_fill_q : sync_fill_q + 2'd1;
    armed_d     = armed_q | ((sync_fill_q == 2'd3) & ncs_pipe_q[1] & ncs_pipe_q[2]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_pipe_q <= 3'b000;
      ncs_pipe_q  <= 3'b111;
      mosi_pipe_q <= 3'b000;
      sync_fill_q <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      ncs_pipe_q  <= ncs_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      sync_fill_q <= sync_fill_d;
      armed_q     <= armed_d;
    end
  end

  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, mosi_bit;

  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign ncs_rise  = ncs_pipe_q[1] & ~ncs_pipe_q[2];
  assign ncs_fall  = ~ncs_pipe_q[1] & ncs_pipe_q[2];
  // MOSI is taken from its history flop: in the cycle a clock rise is detected
  // this is the data as it stood just before the SPI_clk edge, matching the
  // alignment of the SPI_clk history flop.
  assign mosi_bit  = mosi_pipe_q[2];

  // ---------------------------------------------------------------------------
  // Frame state machine and datapath
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             miso_q, miso_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_ack_q, tx_ack_d;
  logic             frame_error_q, frame_error_d;

  logic [WIDTH-1:0] rx_shift_next;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic             word_done;

  assign rx_shift_next = {rx_shift_q[WIDTH-2:0], mosi_bit};
  assign bit_cnt_inc   = (bit_cnt_q == CNT_FULL) ? bit_cnt_q : bit_cnt_q + 1'b1;
  // The rise that carries the final bit. It takes priority over a coincident
  // nCS rise so a frame ended right on its last edge still completes.
  assign word_done     = sclk_rise & (bit_cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    miso_d        = miso_q;
    rx_valid_d    = 1'b0;
    tx_ack_d      = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (armed_q && ncs_fall) begin
          tx_shift_d = tx_data;
          tx_ack_d   = 1'b1;
          miso_d     = tx_data[WIDTH-1];
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (word_done) begin
          rx_shift_d = rx_shift_next;
          bit_cnt_d  = bit_cnt_inc;
          rx_data_d  = rx_shift_next;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = ncs_rise ? S_IDLE : S_WAIT_CS;
        end else if (ncs_rise) begin
          // Frame aborted before all bits arrived: keep the old rx_data.
          frame_error_d = 1'b1;
          miso_d        = 1'b0;
          state_d       = S_IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = rx_shift_next;
          bit_cnt_d  = bit_cnt_inc;
        end else if (sclk_fall && (bit_cnt_q < CNT_FULL)) begin
          tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          miso_d     = tx_shift_q[WIDTH-2];
        end
      end

      S_WAIT_CS: begin
        // Extra SPI_clk pulses past the last bit are ignored here.
        miso_d = 1'b0;
        if (ncs_rise) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ack_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      miso_q        <= miso_d;
      rx_valid_q    <= rx_valid_d;
      tx_ack_q      <= tx_ack_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ack      = tx_ack_q;
  assign frame_error = frame_error_q;

endmodule
